imuldiv_mul_iter_param: RTL and testbench
=========================================

// Module: imuldiv_mul_iter_param
// PURPOSE
//  Parametrised iterative shift-add multiplier, next generation of the lab-1 mul unit.
//  Width-generic; signed/unsigned/mixed modes per request (mul, mulhu, mulhsu).
//  Optional early termination once remaining multiplier bits are zero.
//  Sits behind the imuldiv val/rdy request/response interface; one op in flight.
// PARAMETERS
//  WIDTH       32  operand width in bits (>=4); result is 2*WIDTH
//  EARLY_TERM  1   1: leave CALC when remaining |b| is zero; 0: fixed WIDTH CALC cycles
// PORTS
//  clk                 in   1        clock, all state updates on posedge
//  reset               in   1        asynchronous, active-low reset
//  mulreq_msg_a        in   WIDTH    operand A (multiplicand)
//  mulreq_msg_b        in   WIDTH    operand B (multiplier)
//  mulreq_msg_mode     in   2        00 signed*signed, 01 unsigned*unsigned, 10 signed(A)*unsigned(B), 11 reserved=01
//  mulreq_val          in   1        request valid
//  mulreq_rdy          out  1        request ready (high only in IDLE)
//  mulresp_msg_result  out  2*WIDTH  full product, two's complement when signed
//  mulresp_val         out  1        response valid (high only in DONE)
//  mulresp_rdy         in   1        response ready
//  busy                out  1        high in CALC or DONE
// BEHAVIOUR
//  - Reset low (any time, incl. mid-op): state=IDLE, all regs 0; mulreq_rdy=1,
//    mulresp_val=0, busy=0, mulresp_msg_result=0. Op in flight discarded, no response.
//  - States IDLE -> CALC -> DONE -> IDLE; 2-bit encoding, 11 unreachable, decodes to IDLE.
//  - IDLE: accept on posedge with mulreq_val&&mulreq_rdy. Latch |A|, |B| per mode
//    (magnitude only for signed operands with MSB set), sign_reg = sA^sB for
//    signed operands (unsigned operand contributes sign 0), result_reg=0,
//    counter=WIDTH-1. Next state CALC.
//  - CALC, one multiplier bit per cycle: if b_reg[0] result_reg += a_reg;
//    a_reg <<= 1 (2*WIDTH wide, no overflow possible); b_reg >>= 1; counter--.
//    Exit to DONE after the cycle where counter==0.
//    EARLY_TERM=1: if b_reg==0 at start of a CALC cycle, no add, go to DONE that edge.
//  - Latency accept-edge to mulresp_val: EARLY_TERM=0: WIDTH+1 cycles exactly.
//    EARLY_TERM=1: k+2 cycles, k = index of highest set bit of |B| (+1 cycle)
//    ; |B|==0 -> 2 cycles. Never exceeds WIDTH+1.
//  - DONE: mulresp_val=1; result = sign_reg ? -result_reg : result_reg (2*WIDTH).
//    Result and val held stable until mulresp_rdy; on val&&rdy edge go IDLE.
//    mulreq_rdy=0 in DONE: no same-cycle accept (one-cycle bubble is intentional).
//  - Request inputs ignored outside IDLE; mulreq_msg_* may change freely after accept.
//  - Boundary: A=-2^(W-1) magnitude 2^(W-1) fits WIDTH unsigned; (-2^(W-1))^2 =
//    2^(2W-2) positive, exact. Unsigned (2^W-1)^2 fits 2*WIDTH exactly.
//  - Counter width $clog2(WIDTH); counter wrap never observed (exit at 0).
// STRUCTURE
//  - Package imuldiv_pkg: mode constants (MUL_SS, MUL_UU, MUL_SU), state encoding
//    (ST_IDLE/ST_CALC/ST_DONE), shared by the future iterative div unit.
//  - Sub-module imuldiv_mul_iter_param_dpath: a/b/result/counter/sign regs, magnitude
//    and final negate logic; status outputs b_lsb, b_zero, cntr_zero.
//  - Top holds the FSM and val/rdy decode; control signals are enables and mux selects.
// TESTING
//  - WIDTH=32, SS: A=-7, B=6 -> result 64'hFFFF_FFFF_FFFF_FFD6 (-42); EARLY_TERM=0 val at +33.
//  - UU: A=B=32'hFFFF_FFFF -> 64'hFFFF_FFFE_0000_0001; SS same bits -> 64'h1.
//  - SU: A=-1, B=32'h8000_0000 -> 64'hFFFF_FFFF_8000_0000; SS: A=B=32'h8000_0000 -> 64'h4000_0000_0000_0000.
//  - EARLY_TERM=1: B=0 -> result 0, val 2 cycles after accept; B=1 -> 3 cycles; B=32'h8000_0000 UU -> 33.
//  - Backpressure: hold mulresp_rdy=0 10 cycles -> val/result stable, mulreq_rdy=0; new
//    mulreq_val in DONE not accepted until one cycle after response handshake.
//  - Assert reset low mid-CALC (cycle 10) -> next cycle mulreq_rdy=1, val=0, result=0; fresh op 3*4=12.

Source files
------------

// File: rtl/imuldiv_pkg.sv
`default_nettype none
// ============================================================================
// Package : imuldiv_pkg
// Purpose : Shared definitions for the iterative imuldiv units: multiply
//           mode encodings, the IDLE/CALC/DONE state encoding and operand
//           signedness helpers.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package imuldiv_pkg;

  // Multiply modes; 2'b11 is reserved and behaves as unsigned*unsigned.
  localparam logic [1:0] MUL_SS = 2'b00;
  localparam logic [1:0] MUL_UU = 2'b01;
  localparam logic [1:0] MUL_SU = 2'b10;

  // 2'b11 is unreachable and is treated as IDLE by the FSMs.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic mode_signed_a(input logic [1:0] mode);
    return (mode == MUL_SS) || (mode == MUL_SU);
  endfunction

  function automatic logic mode_signed_b(input logic [1:0] mode);
    return (mode == MUL_SS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imuldiv_mul_iter_param_if.sv
`default_nettype none
// ============================================================================
// Interface : imuldiv_mul_iter_param_if
// Purpose   : val/rdy request/response bundle of the iterative multiplier.
// Signals   : mulreq_msg_a/b (WIDTH), mulreq_msg_mode (2), mulreq_val,
//             mulreq_rdy, mulresp_msg_result (2*WIDTH), mulresp_val,
//             mulresp_rdy, busy.
//             master = requester side, slave = multiplier side.
// Revision  : 1.0 - initial release
// ============================================================================
interface imuldiv_mul_iter_param_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   mulreq_msg_a;
  logic [WIDTH-1:0]   mulreq_msg_b;
  logic [1:0]         mulreq_msg_mode;
  logic               mulreq_val;
  logic               mulreq_rdy;
  logic [2*WIDTH-1:0] mulresp_msg_result;
  logic               mulresp_val;
  logic               mulresp_rdy;
  logic               busy;

  modport master (
    output mulreq_msg_a, mulreq_msg_b, mulreq_msg_mode, mulreq_val, mulresp_rdy,
    input  mulreq_rdy, mulresp_msg_result, mulresp_val, busy
  );

  modport slave (
    input  mulreq_msg_a, mulreq_msg_b, mulreq_msg_mode, mulreq_val, mulresp_rdy,
    output mulreq_rdy, mulresp_msg_result, mulresp_val, busy
  );
endinterface
`default_nettype wire

// File: rtl/imuldiv_mul_iter_param_dpath.sv
`default_nettype none
// ============================================================================
// Module  : imuldiv_mul_iter_param_dpath
// Purpose : Datapath of the iterative shift-add multiplier. Holds the
//           shifted multiplicand, remaining multiplier bits, partial product,
//           iteration counter and result sign; forms operand magnitudes on
//           load and the signed result on output.
// Ports   : clk, reset (async, active-low)
//           load   - capture operands (magnitudes) and clear partial product
//           step   - one iteration: shift a/b, decrement counter
//           add_en - accumulate a_reg during this step
//           a_in, b_in, mode - request operands
//           b_lsb, b_zero, cntr_zero - status to control
//           result - final signed/unsigned product (2*WIDTH)
// Revision: 1.0 - initial release
// ============================================================================
module imuldiv_mul_iter_param_dpath
  import imuldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               load,
  input  wire logic               step,
  input  wire logic               add_en,
  input  wire logic [WIDTH-1:0]   a_in,
  input  wire logic [WIDTH-1:0]   b_in,
  input  wire logic [1:0]         mode,
  output logic                    b_lsb,
  output logic                    b_zero,
  output logic                    cntr_zero,
  output logic [2*WIDTH-1:0]      result
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] a_reg;
  logic [2*WIDTH-1:0] result_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [CW-1:0]      counter;
  logic               sign_reg;

  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits as unsigned.
  always_comb begin
    neg_a = mode_signed_a(mode) && a_in[WIDTH-1];
    neg_b = mode_signed_b(mode) && b_in[WIDTH-1];
    a_mag = neg_a ? -a_in : a_in;
    b_mag = neg_b ? -b_in : b_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      counter    <= '0;
      sign_reg   <= 1'b0;
    end else if (load) begin
      a_reg      <= {{WIDTH{1'b0}}, a_mag};
      b_reg      <= b_mag;
      result_reg <= '0;
      counter    <= CW'(WIDTH - 1);
      sign_reg   <= neg_a ^ neg_b;
    end else if (step) begin
      if (add_en) begin
        result_reg <= result_reg + a_reg;
      end
      a_reg   <= a_reg << 1;
      b_reg   <= b_reg >> 1;
      counter <= counter - CW'(1);
    end
  end

  always_comb begin
    b_lsb     = b_reg[0];
    b_zero    = (b_reg == '0);
    cntr_zero = (counter == '0);
    result    = sign_reg ? -result_reg : result_reg;
  end

endmodule
`default_nettype wire

// File: rtl/imuldiv_mul_iter_param.sv
`default_nettype none
// ============================================================================
// Module  : imuldiv_mul_iter_param
// Purpose : Width-generic iterative shift-add multiplier (mul/mulhu/mulhsu
//           modes) behind a val/rdy request/response interface, one op in
//           flight. Optional early exit once the remaining multiplier bits
//           are all zero.
// Ports   : clk   - clock
//           reset - asynchronous, active-low reset
//           io    - imuldiv_mul_iter_param_if.slave (request, response, busy)
// Revision: 1.0 - initial release
// ============================================================================
module imuldiv_mul_iter_param
  import imuldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int EARLY_TERM = 1
) (
  input wire logic               clk,
  input wire logic               reset,
  imuldiv_mul_iter_param_if.slave io
);

  state_t state;
  logic   req_rdy;
  logic   resp_val;
  logic   busy_r;

  logic   b_lsb;
  logic   b_zero;
  logic   cntr_zero;
  logic   load;
  logic   step;
  logic   add_en;
  logic   early_exit;
  logic   calc_exit;

  always_comb begin
    early_exit = (EARLY_TERM != 0) && b_zero;
    calc_exit  = early_exit || cntr_zero;
    load       = (state == ST_IDLE) && io.mulreq_val && req_rdy;
    // An early-exit cycle does no work; it only moves the FSM to DONE.
    step       = (state == ST_CALC) && !early_exit;
    add_en     = step && b_lsb;
  end

  // Handshake outputs are registered alongside the state so they change
  // exactly with the state transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      req_rdy  <= 1'b1;
      resp_val <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state   <= ST_CALC;
            req_rdy <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        ST_CALC: begin
          if (calc_exit) begin
            state    <= ST_DONE;
            resp_val <= 1'b1;
          end
        end
        ST_DONE: begin
          // Ready rises only after the response handshake, leaving a
          // deliberate one-cycle bubble before the next accept.
          if (io.mulresp_rdy) begin
            state    <= ST_IDLE;
            resp_val <= 1'b0;
            busy_r   <= 1'b0;
            req_rdy  <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          req_rdy  <= 1'b1;
          resp_val <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign io.mulreq_rdy  = req_rdy;
  assign io.mulresp_val = resp_val;
  assign io.busy        = busy_r;

  imuldiv_mul_iter_param_dpath #(
    .WIDTH (WIDTH)
  ) u_dpath (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .add_en    (add_en),
    .a_in      (io.mulreq_msg_a),
    .b_in      (io.mulreq_msg_b),
    .mode      (io.mulreq_msg_mode),
    .b_lsb     (b_lsb),
    .b_zero    (b_zero),
    .cntr_zero (cntr_zero),
    .result    (io.mulresp_msg_result)
  );

endmodule
`default_nettype wire

// File: tb/tb_imuldiv_mul_iter_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_imuldiv_mul_iter_param
// Purpose : Self-checking bench for imuldiv_mul_iter_param. Two instances
//           (fixed-length and early-terminating) receive identical requests.
// Revision: 1.0 - initial release
// ============================================================================
module tb_imuldiv_mul_iter_param;

  localparam int W = 32;

  logic clk;
  logic reset;

  imuldiv_mul_iter_param_if #(.WIDTH(W)) if0 ();
  imuldiv_mul_iter_param_if #(.WIDTH(W)) if1 ();

  imuldiv_mul_iter_param #(.WIDTH(W), .EARLY_TERM(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .io    (if0)
  );

  imuldiv_mul_iter_param #(.WIDTH(W), .EARLY_TERM(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .io    (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_res  = '0;
  logic [63:0] exp_lit  = '0;
  int          exp_lat1 = 0;
  logic [63:0] pend_exp;
  logic [63:0] pend_lit;
  int          pend_lat1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product: extend each operand to 64 bits by its mode's rule
  // and multiply; the low 64 bits are the exact 2*W-bit product.
  function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] m);
    longint ea;
    longint eb;
    longint p;
    ea = (m == 2'b00 || m == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
    eb = (m == 2'b00) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = ea * eb;
    return 64'(p);
  endfunction

  // Early-terminating latency: 2 for |B|==0, else highest set bit + 3,
  // never more than W+1.
  function automatic int model_lat1(input logic [31:0] b, input logic [1:0] m);
    logic [31:0] mag;
    int          k;
    mag = (m == 2'b00 && b[31]) ? (32'd0 - b) : b;
    if (mag == 32'd0) return 2;
    k = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) k = i;
    return (k + 3 > W + 1) ? W + 1 : k + 3;
  endfunction

  task automatic present(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                         input logic [63:0] lit);
    pend_exp  = model_mul(a, b, m);
    pend_lit  = lit;
    pend_lat1 = model_lat1(b, m);
    if0.mulreq_msg_a = a; if0.mulreq_msg_b = b; if0.mulreq_msg_mode = m; if0.mulreq_val = 1'b1;
    if1.mulreq_msg_a = a; if1.mulreq_msg_b = b; if1.mulreq_msg_mode = m; if1.mulreq_val = 1'b1;
  endtask

  // Accept edge; afterwards the request fields are scrambled, which must
  // not affect the operation in flight.
  task automatic accept();
    @(posedge clk);
    exp_res  = pend_exp;
    exp_lit  = pend_lit;
    exp_lat1 = pend_lat1;
    #1;
    if0.mulreq_val = 1'b0; if1.mulreq_val = 1'b0;
    if0.mulreq_msg_a = $urandom; if0.mulreq_msg_b = $urandom;
    if0.mulreq_msg_mode = 2'($urandom_range(0, 3));
    if1.mulreq_msg_a = $urandom; if1.mulreq_msg_b = $urandom;
    if1.mulreq_msg_mode = 2'($urandom_range(0, 3));
  endtask

  // Latency counts the accept edge as cycle 1.
  task automatic wait_done();
    int cyc;
    int l0;
    int l1;
    cyc = 1; l0 = 0; l1 = 0;
    forever begin
      @(negedge clk);
      if (l0 == 0 && if0.mulresp_val) l0 = cyc;
      if (l1 == 0 && if1.mulresp_val) l1 = cyc;
      if ((l0 != 0 && l1 != 0) || cyc >= 40) break;
      @(posedge clk);
      cyc++;
    end
    chk("latency_et0", 64'(l0), 64'(W + 1));
    chk("latency_et1", 64'(l1), 64'(exp_lat1));
    chk("literal_et0", if0.mulresp_msg_result, exp_lit);
    chk("literal_et1", if1.mulresp_msg_result, exp_lit);
  endtask

  task automatic finish(input int hold);
    repeat (hold) @(posedge clk);
    #1;
    if0.mulresp_rdy = 1'b1; if1.mulresp_rdy = 1'b1;
    @(posedge clk);
    #1;
    if0.mulresp_rdy = 1'b0; if1.mulresp_rdy = 1'b0;
    @(negedge clk);
    chk("val_after_hs0", 64'(if0.mulresp_val), 64'(0));
    chk("val_after_hs1", 64'(if1.mulresp_val), 64'(0));
    chk("rdy_after_hs0", 64'(if0.mulreq_rdy), 64'(1));
    chk("rdy_after_hs1", 64'(if1.mulreq_rdy), 64'(1));
    chk("busy_after_hs0", 64'(if0.busy), 64'(0));
    chk("busy_after_hs1", 64'(if1.busy), 64'(0));
  endtask

  // Per-cycle compare: while a response is valid it must equal the model
  // and no new request may be accepted; rdy is always the inverse of busy.
  always @(negedge clk) begin
    if (reset) begin
      chk("rdy_vs_busy0", 64'(if0.mulreq_rdy), 64'(!if0.busy));
      chk("rdy_vs_busy1", 64'(if1.mulreq_rdy), 64'(!if1.busy));
      if (if0.mulresp_val) begin
        chk("result_et0", if0.mulresp_msg_result, exp_res);
        chk("rdy_in_done0", 64'(if0.mulreq_rdy), 64'(0));
      end
      if (if1.mulresp_val) begin
        chk("result_et1", if1.mulresp_msg_result, exp_res);
        chk("rdy_in_done1", 64'(if1.mulreq_rdy), 64'(0));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_rdy0"}, 64'(if0.mulreq_rdy), 64'(1));
    chk({tag, "_rdy1"}, 64'(if1.mulreq_rdy), 64'(1));
    chk({tag, "_val0"}, 64'(if0.mulresp_val), 64'(0));
    chk({tag, "_val1"}, 64'(if1.mulresp_val), 64'(0));
    chk({tag, "_busy0"}, 64'(if0.busy), 64'(0));
    chk({tag, "_busy1"}, 64'(if1.busy), 64'(0));
    chk({tag, "_res0"}, if0.mulresp_msg_result, 64'h0);
    chk({tag, "_res1"}, if1.mulresp_msg_result, 64'h0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                        input logic [63:0] lit, input int hold);
    present(a, b, m, lit);
    accept();
    wait_done();
    finish(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    if0.mulreq_msg_a = '0; if0.mulreq_msg_b = '0; if0.mulreq_msg_mode = '0;
    if0.mulreq_val = 1'b0; if0.mulresp_rdy = 1'b0;
    if1.mulreq_msg_a = '0; if1.mulreq_msg_b = '0; if1.mulreq_msg_mode = '0;
    if1.mulreq_val = 1'b0; if1.mulresp_rdy = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1 reset = 1'b1;

    run_op(32'hFFFF_FFF9, 32'd6,        2'b00, 64'hFFFF_FFFF_FFFF_FFD6, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 64'hFFFF_FFFE_0000_0001, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 64'h0000_0000_0000_0001, 1);
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 2'b10, 64'hFFFF_FFFF_8000_0000, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 2'b00, 64'h4000_0000_0000_0000, 0);
    run_op(32'd12345,     32'd0,        2'b01, 64'h0, 0);
    run_op(32'd5,         32'd1,        2'b01, 64'h5, 2);
    run_op(32'hFFFF_FFFF, 32'd2,        2'b11, 64'h0000_0001_FFFF_FFFE, 0);
    run_op(32'd3,         32'hFFFF_FFFF, 2'b10, 64'h0000_0002_FFFF_FFFD, 0);
    run_op(32'd5,         32'hFFFF_FFFD, 2'b00, 64'hFFFF_FFFF_FFFF_FFF1, 0);

    // Backpressure with a new request waiting during DONE.
    present(32'd100, 32'd200, 2'b01, 64'd20000);
    accept();
    wait_done();
    present(32'hFFFF_FFFE, 32'hFFFF_FFFD, 2'b00, 64'd6);
    finish(10);
    accept();
    wait_done();
    finish(0);

    // Reset in the middle of a calculation.
    present(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 64'hFFFF_FFFE_0000_0001);
    accept();
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_state("midreset");
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_reset_state("post_reset");
    run_op(32'd3, 32'd4, 2'b01, 64'd12, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
